// File: rtl/dspb_serum_nios2_dbg_pkg.sv
// rtl/dspb_serum_nios2_dbg_pkg.sv - shared types and jdo field positions for the debug memory engine
package dspb_serum_nios2_dbg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } mem_state_t;

    localparam int JDO_ERRCLR  = 35;
    localparam int JDO_RDREQ   = 34;
    localparam int JDO_ADDR_HI = 31;
    localparam int JDO_ADDR_LO = 2;
    localparam int JDO_DATA_HI = 31;
    localparam int JDO_DATA_LO = 0;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/dspb_serum_nios2_bus_timeout.sv
// rtl/dspb_serum_nios2_bus_timeout.sv - saturating stall counter flagging the last allowed request cycle
module dspb_serum_nios2_bus_timeout #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [15:0] LAST = 16'(LIMIT - 1);

    logic [15:0] count;

    // Saturates at LAST so a long stall never wraps back below the limit.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + 16'd1;
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/dspb_serum_nios2_jtag_mem_engine.sv
// rtl/dspb_serum_nios2_jtag_mem_engine.sv - turns debug-module ocimem strobes into single-word bus reads/writes
module dspb_serum_nios2_jtag_mem_engine
    import dspb_serum_nios2_dbg_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter logic [31:0] RESET_ADDR     = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [37:0] jdo,
    input  logic        take_action_ocimem_a,
    input  logic        take_action_ocimem_b,
    input  logic        take_no_action_ocimem_a,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic [31:0] MonDReg,
    output logic        monitor_ready,
    output logic        monitor_error,
    output logic        busy
);

    mem_state_t  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] mon_q, mon_d;
    logic [31:0] wdata_q, wdata_d;
    logic        ready_q, ready_d;
    logic        error_q, error_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic        any_strobe;
    logic        expired;
    logic        unused_jdo_bits;

    assign unused_jdo_bits = ^{jdo[37:36], jdo[33:32], jdo[1:0]};
    assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

    // Counter is held clear while idle so every new request starts from zero.
    dspb_serum_nios2_bus_timeout #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_q == ST_IDLE),
        .enable  ((state_q != ST_IDLE) && avm_waitrequest),
        .expired (expired)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        mon_d   = mon_q;
        wdata_d = wdata_q;
        ready_d = ready_q;
        error_d = error_q;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (take_action_ocimem_a) begin
                    if (jdo[JDO_ERRCLR]) begin
                        error_d = 1'b0;
                    end
                    addr_d = {jdo[JDO_ADDR_HI:JDO_ADDR_LO], 2'b00};
                    if (jdo[JDO_RDREQ]) begin
                        state_d = ST_RD;
                        rd_d    = 1'b1;
                        ready_d = 1'b0;
                    end else begin
                        ready_d = 1'b1;
                    end
                end else if (take_action_ocimem_b) begin
                    mon_d   = jdo[JDO_DATA_HI:JDO_DATA_LO];
                    wdata_d = jdo[JDO_DATA_HI:JDO_DATA_LO];
                    state_d = ST_WR;
                    wr_d    = 1'b1;
                    ready_d = 1'b0;
                end else if (take_no_action_ocimem_a) begin
                    state_d = ST_RD;
                    rd_d    = 1'b1;
                    ready_d = 1'b0;
                end
            end
            ST_RD, ST_WR: begin
                if (any_strobe) begin
                    error_d = 1'b1;
                end
                // Completion is tested first so a grant on the last allowed cycle is not an error.
                if (!avm_waitrequest) begin
                    if (state_q == ST_RD) begin
                        mon_d = avm_readdata;
                    end
                    addr_d  = addr_q + 32'd4;
                    ready_d = 1'b1;
                    state_d = ST_IDLE;
                end else if (expired) begin
                    error_d = 1'b1;
                    ready_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    rd_d = (state_q == ST_RD);
                    wr_d = (state_q == ST_WR);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= RESET_ADDR;
            mon_q   <= '0;
            wdata_q <= '0;
            ready_q <= 1'b0;
            error_q <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            mon_q   <= mon_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            error_q <= error_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    assign avm_address    = addr_q;
    assign avm_read       = rd_q;
    assign avm_write      = wr_q;
    assign avm_writedata  = wdata_q;
    assign avm_byteenable = 4'hF;
    assign MonDReg        = mon_q;
    assign monitor_ready  = ready_q;
    assign monitor_error  = error_q;
    assign busy           = (state_q != ST_IDLE);

endmodule

// File: doc/dspb_serum_nios2_jtag_mem_engine.md
# dspb_serum_nios2_jtag_mem_engine

Debug-monitor memory access engine for the Nios II debug path in `dspb_serum_qsys`. It sits directly downstream of the JTAG debug module's sysclk stage and consumes its `jdo` word and `take_*_ocimem_*` strobes. It turns them into single-word Avalon-MM master reads and writes with address auto-increment and a bus timeout. It returns `MonDReg`, `monitor_ready` and `monitor_error` to the debug module's tck stage.

## Interface
- `TIMEOUT_CYCLES`, 1024: consecutive cycles a request may stall on `avm_waitrequest` before it is abandoned; legal range 2..65535.
- `RESET_ADDR`, 32'h0000_0000: reset value of the internal address register; must be word-aligned.
- `clk` in 1: the single clock, shared with the debug module's sysclk stage.
- `reset` in 1: synchronous, active-high reset.
- `jdo` in 38: command payload; sampled only in a cycle where a strobe is high.
- `take_action_ocimem_a` in 1: address/control command strobe.
- `take_action_ocimem_b` in 1: write-data command strobe.
- `take_no_action_ocimem_a` in 1: read-next command strobe.
- `avm_address` out 32: byte address, always word-aligned.
- `avm_read` out 1: read request.
- `avm_write` out 1: write request.
- `avm_writedata` out 32: write data.
- `avm_byteenable` out 4: constant 4'hF.
- `avm_readdata` in 32: read data; valid in a cycle with `avm_read` high and `avm_waitrequest` low.
- `avm_waitrequest` in 1: slave stall.
- `MonDReg` out 32: last read data, or the last write data.
- `monitor_ready` out 1: last command completed; high means `MonDReg` is valid.
- `monitor_error` out 1: sticky error flag.
- `busy` out 1: a bus transaction is in flight.

## Operation
- FSM states: IDLE, RD, WR.
- Commands are decoded in IDLE only. Priority is `take_action_ocimem_a` > `take_action_ocimem_b` > `take_no_action_ocimem_a`.
- `take_action_ocimem_a`:
  - If `jdo[35]`, clear `monitor_error`.
  - Load address to {`jdo[31:2]`, 2'b00}.
  - If `jdo[34]`, go to RD at the new address. Otherwise stay IDLE with `monitor_ready` = 1.
- `take_action_ocimem_b`: set `MonDReg` = `jdo[31:0]` and `avm_writedata` = `jdo[31:0]`, then go to WR.
- `take_no_action_ocimem_a`: go to RD at the current address.
- Entering RD or WR clears `monitor_ready` and clears the timeout counter.
- RD: hold `avm_read` = 1 with stable address. On a cycle with `!avm_waitrequest`:
  - capture `MonDReg` ← `avm_readdata`;
  - advance the address by 4;
  - set `monitor_ready` = 1;
  - go to IDLE.
- WR: same completion rule with `avm_write` = 1. `MonDReg` keeps the written data.
- Timeout: if the counter reaches `TIMEOUT_CYCLES`-1 while `avm_waitrequest` is still high:
  - drop the request;
  - set `monitor_error` = 1 and `monitor_ready` = 1;
  - leave `MonDReg` and the address unchanged;
  - go to IDLE.
- A command strobe that arrives in RD or WR is discarded and sets `monitor_error`. The transaction in flight continues.
- Address wraps modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- `jdo[37:36]`, `jdo[33:32]` and `jdo[1:0]` are ignored.

## Timing
- Reset values: state IDLE, address `RESET_ADDR`, `MonDReg` 0, `monitor_ready` 0, `monitor_error` 0, `busy` 0, `avm_read` 0, `avm_write` 0, `avm_writedata` 0.
- A strobe at edge N asserts `avm_read`/`avm_write` from edge N+1.
- With zero wait states, `MonDReg` and `monitor_ready` update at edge N+2, and the request drops at edge N+2.
- Each stall cycle adds one cycle of latency.
- All outputs are registered.
- `avm_address` and `avm_writedata` are stable for the whole request.
- `busy` = (state != IDLE).
- Back-to-back commands are accepted from edge N+2, i.e. the first IDLE cycle.
- Completion and timeout in the same cycle (`!avm_waitrequest` on the last allowed cycle): completion wins and no error is raised.
- Reset asserted mid-transaction: the request is deasserted at the next edge and every register returns to its reset value. No partial completion is reported.

## Structure
- Package `dspb_serum_nios2_dbg_pkg` holds:
  - the FSM state enum;
  - `jdo` field constants: `JDO_ERRCLR` = 35, `JDO_RDREQ` = 34, address field [31:2], data field [31:0];
  - the default `TIMEOUT_CYCLES`.
- One sub-module, `dspb_serum_nios2_bus_timeout`. It is a saturating counter with clear and enable inputs and an `expired` output.

## Test plan
- Set address and read: `take_action_ocimem_a` with `jdo` = {2'b0, 1'b0, 1'b1, 2'b0, 32'h0000_1000}, slave returns 32'hDEAD_BEEF with zero wait → `avm_address` = 32'h1000, `MonDReg` = 32'hDEAD_BEEF at N+2, next address 32'h1004.
- Write with 3 wait states: `take_action_ocimem_b` with data 32'h1234_5678 → `avm_write` held for 4 cycles, `monitor_ready` rises at N+5, address advances by 4.
- Timeout: `avm_waitrequest` stuck high, `TIMEOUT_CYCLES` = 8 → request drops after 8 cycles, `monitor_error` = 1, `monitor_ready` = 1, address unchanged. A following `jdo[35]` clear returns `monitor_error` to 0.
- Wrap: address 32'hFFFF_FFFC, then two `take_no_action_ocimem_a` reads → second read at 32'h0000_0000.
- Command while busy: `take_no_action_ocimem_a` during a stalled WR → strobe ignored, `monitor_error` = 1, write still completes once.
- Reset mid-RD: assert `reset` during stall → `avm_read` = 0 next edge, all outputs at reset values, `monitor_ready` = 0.
